led_pattern_sequencer: RTL and testbench

- Controller for the red/green LED bank scroll datapath.
- Owns the step prescaler and a 4-mode pattern state machine (rotate right, rotate left, bounce, blink).
- Advances modes manually or automatically after a fixed step count, and accepts a runtime pattern load.
- Sits between the board clock/reset pins and the LED output pins, in place of a fixed divider plus scroll pair.

---
 rtl/led_pattern_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - LED bank scroll controller: step prescaler plus four-mode pattern sequencer
//
// Purpose:
//    Drives a red LED bank with a scrolling pattern and a green LED bank with a
//    one-hot mode indicator. A free-running prescaler produces one step per
//    2^DIV_EXP clocks. Each step moves the pattern according to the current
//    mode: rotate right, rotate left, bounce or blink. The mode advances on a
//    mode_next pulse. With auto_en set, it also advances after STEPS_PER_MODE
//    steps. A load pulse replaces the base pattern at runtime.
//
// Ports:
//    clk           in   system clock
//    reset         in   asynchronous, active-high reset
//    auto_en       in   enables automatic mode advance
//    mode_next     in   single-cycle pulse, advance to next mode
//    load          in   single-cycle pulse, capture load_pattern
//    load_pattern  in   [WIDTH] new base pattern
//    led_r         out  [WIDTH] current pattern (registered)
//    led_g         out  [WIDTH] one-hot mode indicator, bit[mode] set (registered)
//    mode          out  [2] current mode: 0=ROT_R, 1=ROT_L, 2=BOUNCE, 3=BLINK
//    step_tick     out  high for one clk cycle per step

module led_pattern_sequencer #(
   parameter int               WIDTH          = 8,
   parameter int               DIV_EXP        = 20,
   parameter int               STEPS_PER_MODE = 16,
   parameter logic [WIDTH-1:0] RESET_PATTERN  = 8'hC0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             auto_en,
   input  logic             mode_next,
   input  logic             load,
   input  logic [WIDTH-1:0] load_pattern,
   output logic [WIDTH-1:0] led_r,
   output logic [WIDTH-1:0] led_g,
   output logic [1:0]       mode,
   output logic             step_tick
);

   // Mode encodings; the increment order is the advance order.
   localparam logic [1:0] MODE_ROT_R  = 2'd0;
   localparam logic [1:0] MODE_ROT_L  = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   // Bounce direction.
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   localparam int              CNT_W     = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEPS_PER_MODE - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DIV_EXP-1:0] prescaler;
   logic [WIDTH-1:0]   pat;
   logic [WIDTH-1:0]   base;
   logic [1:0]         mode_q;
   logic               dir;
   logic [CNT_W-1:0]   step_cnt;

   // ------------------------------------------------------------------
   // Next-state signals
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]   pat_n;
   logic [WIDTH-1:0]   base_n;
   logic [1:0]         mode_n;
   logic               dir_n;
   logic [CNT_W-1:0]   cnt_n;
   logic [WIDTH-1:0]   led_g_n;

   logic [WIDTH-1:0]   rot_r;
   logic [WIDTH-1:0]   rot_l;
   logic [WIDTH-1:0]   step_pat;
   logic               step_dir;
   logic               auto_adv;

   // The tick is the all-ones prescaler state. The first tick therefore
   // lands in cycle 2^DIV_EXP after reset release, and it repeats with
   // that period regardless of loads or mode changes.
   assign step_tick = &prescaler;

   assign rot_r = {pat[0], pat[WIDTH-1:1]};
   assign rot_l = {pat[WIDTH-2:0], pat[WIDTH-1]};

   // Auto advance replaces the step that would have been the last one
   // in the current mode.
   assign auto_adv = step_tick && auto_en && (step_cnt == STEP_LAST);

   // ------------------------------------------------------------------
   // Per-mode step operation
   // ------------------------------------------------------------------
   always_comb begin
      step_pat = pat;
      step_dir = dir;
      case (mode_q)
         MODE_ROT_R: step_pat = rot_r;
         MODE_ROT_L: step_pat = rot_l;
         MODE_BOUNCE: begin
            // When both edge bits are set, the pattern cannot move without
            // one edge bit wrapping, so it holds. Otherwise the pattern
            // reverses as soon as a set bit reaches the edge it is moving
            // toward. This keeps the wrap path of the rotation unused.
            if (pat[0] && pat[WIDTH-1]) begin
               step_pat = pat;
            end else if ((dir == DIR_RIGHT) && pat[0]) begin
               step_dir = DIR_LEFT;
               step_pat = rot_l;
            end else if ((dir == DIR_LEFT) && pat[WIDTH-1]) begin
               step_dir = DIR_RIGHT;
               step_pat = rot_r;
            end else if (dir == DIR_LEFT) begin
               step_pat = rot_l;
            end else begin
               step_pat = rot_r;
            end
         end
         MODE_BLINK: step_pat = ~pat;
         default:    step_pat = pat;
      endcase
   end

   // ------------------------------------------------------------------
   // Priority: load > mode advance (manual or auto) > step
   // ------------------------------------------------------------------
   always_comb begin
      pat_n  = pat;
      base_n = base;
      mode_n = mode_q;
      dir_n  = dir;
      cnt_n  = step_cnt;

      if (load) begin
         // A coincident mode_next still advances the mode. The loaded
         // pattern is the one shown.
         base_n = load_pattern;
         pat_n  = load_pattern;
         dir_n  = DIR_RIGHT;
         cnt_n  = '0;
         if (mode_next) begin
            mode_n = mode_q + 2'd1;
         end
      end else if (mode_next || auto_adv) begin
         // Every mode starts from the base pattern with no shift on the
         // advancing edge. Any coincident step is dropped.
         mode_n = mode_q + 2'd1;
         pat_n  = base;
         dir_n  = DIR_RIGHT;
         cnt_n  = '0;
      end else if (step_tick) begin
         pat_n = step_pat;
         dir_n = step_dir;
         if (auto_en) begin
            cnt_n = step_cnt + 1'b1;
         end
      end

      // Holding auto_en low keeps the count clear. Re-enabling auto advance
      // therefore always gives the full number of steps.
      if (!auto_en) begin
         cnt_n = '0;
      end

      led_g_n = WIDTH'(1) << mode_n;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         pat       <= RESET_PATTERN;
         base      <= RESET_PATTERN;
         mode_q    <= MODE_ROT_R;
         dir       <= DIR_RIGHT;
         step_cnt  <= '0;
         led_r     <= RESET_PATTERN;
         led_g     <= WIDTH'(1);
      end else begin
         prescaler <= prescaler + 1'b1;
         pat       <= pat_n;
         base      <= base_n;
         mode_q    <= mode_n;
         dir       <= dir_n;
         step_cnt  <= cnt_n;
         led_r     <= pat_n;
         led_g     <= led_g_n;
      end
   end

   assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer

module tb_led_pattern_sequencer;

   localparam int         W   = 8;
   localparam int         DE  = 2;
   localparam int         SPM = 4;
   localparam logic [7:0] RP  = 8'hC0;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         auto_en = 1'b0;
   logic         mode_next = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_pattern = '0;
   logic [W-1:0] led_r;
   logic [W-1:0] led_g;
   logic [1:0]   mode;
   logic         step_tick;

   led_pattern_sequencer #(
      .WIDTH(W), .DIV_EXP(DE), .STEPS_PER_MODE(SPM), .RESET_PATTERN(RP)
   ) dut (
      .clk(clk), .reset(reset), .auto_en(auto_en), .mode_next(mode_next),
      .load(load), .load_pattern(load_pattern), .led_r(led_r), .led_g(led_g),
      .mode(mode), .step_tick(step_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles since reset modulo the step period,
   // current/base pattern, mode number, bounce heading (0 right, 1 left),
   // and steps taken in the current mode.
   int           m_phase;
   logic [W-1:0] m_pat;
   logic [W-1:0] m_base;
   int           m_mode;
   int           m_dir;
   int           m_steps;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pat   = RP;
      m_base  = RP;
      m_mode  = 0;
      m_dir   = 0;
      m_steps = 0;
   endtask

   task automatic model_step();
      logic [W-1:0] right_p;
      logic [W-1:0] left_p;
      logic         lo;
      logic         hi;
      right_p = (m_pat >> 1) | (W'(m_pat[0]) << (W - 1));
      left_p  = (m_pat << 1) | W'(m_pat[W-1]);
      lo = m_pat[0];
      hi = m_pat[W-1];
      case (m_mode)
         0: m_pat = right_p;
         1: m_pat = left_p;
         2: begin
            if (lo && hi) m_pat = m_pat;
            else if (m_dir == 0 && lo) begin m_dir = 1; m_pat = left_p; end
            else if (m_dir == 1 && hi) begin m_dir = 0; m_pat = right_p; end
            else m_pat = (m_dir == 1) ? left_p : right_p;
         end
         default: m_pat = ~m_pat;
      endcase
   endtask

   // One clock: drive inputs, check step_tick mid-cycle, let the edge
   // happen, update the model and check the registered outputs.
   task automatic run_cycle(input bit ae, input bit mn, input bit ld,
                            input logic [W-1:0] lp, output bit tk);
      auto_en = ae; mode_next = mn; load = ld; load_pattern = lp;
      @(negedge clk);
      tk = (m_phase == (1 << DE) - 1);
      check("step_tick", step_tick, tk);
      @(posedge clk);
      if (ld) begin
         m_base = lp; m_pat = lp; m_dir = 0; m_steps = 0;
         if (mn) m_mode = (m_mode + 1) % 4;
      end else if (mn || (tk && ae && m_steps == SPM - 1)) begin
         m_mode = (m_mode + 1) % 4; m_pat = m_base; m_dir = 0; m_steps = 0;
      end else if (tk) begin
         model_step();
         if (ae) m_steps++;
      end
      if (!ae) m_steps = 0;
      m_phase = (m_phase + 1) % (1 << DE);
      #1;
      check("led_r", led_r, m_pat);
      check("led_g", led_g, 32'(1) << m_mode);
      check("mode", mode, m_mode);
      mode_next = 1'b0; load = 1'b0;
   endtask

   // Idle until a step tick has been consumed, then compare led_r to a constant.
   task automatic to_tick(input bit ae, input string tag, input logic [7:0] exp);
      bit tk;
      int n;
      tk = 0; n = 0;
      while (!tk && n < 8) begin
         run_cycle(ae, 0, 0, '0, tk);
         n++;
      end
      check({tag, "_tick_seen"}, tk, 1);
      check(tag, led_r, exp);
   endtask

   // Idle until the next cycle is a tick cycle.
   task automatic align_to_tick_cycle(input bit ae);
      bit tk;
      int n;
      n = 0;
      while (m_phase != (1 << DE) - 1 && n < 8) begin
         run_cycle(ae, 0, 0, '0, tk);
         n++;
      end
   endtask

   task automatic async_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_led_r", led_r, RP);
      check("rst_led_g", led_g, 8'h01);
      check("rst_mode", mode, 0);
      check("rst_step_tick", step_tick, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   logic [7:0] rot_r_seq [8]  = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};
   logic [7:0] bounce_seq[13] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06,
                                  8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60};

   initial begin
      bit           tk;
      bit           ae;
      logic [W-1:0] lp;

      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      check("reset_led_r", led_r, 8'hC0);
      check("reset_led_g", led_g, 8'h01);
      check("reset_mode", mode, 0);

      // Rotate right through one full revolution.
      for (int i = 0; i < 8; i++) to_tick(0, "rot_r", rot_r_seq[i]);

      // Rotate left starts from the base pattern.
      run_cycle(0, 1, 0, '0, tk);
      check("rot_l_entry", led_r, 8'hC0);
      to_tick(0, "rot_l", 8'h81);
      to_tick(0, "rot_l", 8'h03);
      to_tick(0, "rot_l", 8'h06);

      // Bounce from C0, then a pattern with both edge bits set holds.
      run_cycle(0, 1, 0, '0, tk);
      check("bounce_mode", mode, 2);
      for (int i = 0; i < 13; i++) to_tick(0, "bounce", bounce_seq[i]);
      run_cycle(0, 0, 1, 8'h81, tk);
      for (int i = 0; i < 3; i++) to_tick(0, "bounce_hold", 8'h81);

      // Blink from base C0, then mode_next on a tick cycle suppresses the toggle.
      run_cycle(0, 0, 1, 8'hC0, tk);
      run_cycle(0, 1, 0, '0, tk);
      check("blink_mode", mode, 3);
      to_tick(0, "blink", 8'h3F);
      to_tick(0, "blink", 8'hC0);
      align_to_tick_cycle(0);
      run_cycle(0, 1, 0, '0, tk);
      check("mn_on_tick_was_tick", tk, 1);
      check("mn_on_tick_mode", mode, 0);
      check("mn_on_tick_led_r", led_r, 8'hC0);

      // Auto advance after SPM-1 executed steps.
      to_tick(1, "auto", 8'h60);
      to_tick(1, "auto", 8'h30);
      to_tick(1, "auto", 8'h18);
      to_tick(1, "auto_adv_led_r", 8'hC0);
      check("auto_adv_mode", mode, 1);

      // Load plus mode_next on a tick edge.
      align_to_tick_cycle(0);
      run_cycle(0, 1, 1, 8'h18, tk);
      check("ld_mn_mode", mode, 2);
      check("ld_mn_led_r", led_r, 8'h18);

      // Asynchronous reset partway through a cycle.
      run_cycle(0, 0, 0, '0, tk);
      async_reset();

      // Randomized traffic against the model.
      ae = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 40) == 0) ae = ~ae;
         case ($urandom_range(0, 3))
            0:       lp = '0;
            1:       lp = 8'h81;
            default: lp = W'($urandom);
         endcase
         run_cycle(ae, $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0, lp, tk);
         if ($urandom_range(0, 700) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
